// File: rtl/svm_dot_ctrl_if.sv
// Command/result handshake between the SVM top-level control and the dot-product sequencer.
// master = SVM control side, slave = svm_dot_ctrl.
interface svm_dot_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11,
    parameter int ACC_W  = 48
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_ovf;
    logic              busy;

    modport master (
        output cmd_valid, cmd_base, cmd_len, res_ready,
        input  cmd_ready, res_valid, res_data, res_ovf, busy
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, res_ready,
        output cmd_ready, res_valid, res_data, res_ovf, busy
    );
endinterface

// File: rtl/svm_dot_ctrl.sv
// SVM kernel dot-product sequencer: streams operand pairs through the shared pipelined multiplier
// and accumulates the products. Optional saturating accumulate: define SVM_DOT_SAT_EN.
module svm_dot_ctrl #(
    parameter int MUL_W   = 17,
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 48,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 11,
    parameter int MUL_LAT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    svm_dot_ctrl_if.slave     ctl,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [MUL_W-1:0]  rd_data_a,
    input  logic [MUL_W-1:0]  rd_data_b,
    output logic              mul_en,
    output logic              mul_start,
    output logic [MUL_W-1:0]  mul_a,
    output logic [MUL_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_r;
    logic                cmd_ready_r, busy_r, res_valid_r, res_ovf_r;
    logic [ACC_W-1:0]    res_data_r;
    logic                rd_en_r, mul_start_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                rd_pend_r, op_vld_r;
    logic [MUL_W-1:0]    mul_a_r, mul_b_r;
    logic [MUL_LAT-1:0]  vpipe_r;
    logic [ACC_W-1:0]    acc_r, acc_nxt_s, sum_s;
    logic                ovf_r, ovf_nxt_s, ovf_add_s;
    logic                cap_s, drained_s;

    // Accumulate one sign-extended product; MSB of the result flags a clip.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [PROD_W-1:0] prod);
`ifdef SVM_DOT_SAT_EN
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_add = {1'b1, sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        end else begin
            acc_add = {1'b0, sum[ACC_W-1:0]};
        end
`else
        logic [ACC_W-1:0] sum;
        sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_add = {1'b0, sum};
`endif
    endfunction

    // Capture decision and next accumulator value.
    always_comb begin
        cap_s                = mul_start_r & vpipe_r[MUL_LAT-1];
        {ovf_add_s, sum_s}   = acc_add(acc_r, mul_data);
        if (cap_s) begin
            acc_nxt_s = sum_s;
            ovf_nxt_s = ovf_r | ovf_add_s;
        end else begin
            acc_nxt_s = acc_r;
            ovf_nxt_s = ovf_r;
        end
        // The stream is contiguous, so the last capture is the one with nothing behind it.
        drained_s = cap_s & ~(|vpipe_r[MUL_LAT-2:0]) & ~op_vld_r & ~rd_pend_r;
    end

    // Operand stage and product-valid tracking alongside the multiplier pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r <= 1'b0;
            op_vld_r  <= 1'b0;
            mul_a_r   <= {MUL_W{1'b0}};
            mul_b_r   <= {MUL_W{1'b0}};
            vpipe_r   <= {MUL_LAT{1'b0}};
        end else begin
            rd_pend_r <= rd_en_r;
            op_vld_r  <= rd_pend_r;
            if (rd_pend_r) begin
                mul_a_r <= rd_data_a;
                mul_b_r <= rd_data_b;
            end else begin
                mul_a_r <= {MUL_W{1'b0}};
                mul_b_r <= {MUL_W{1'b0}};
            end
            if (mul_start_r) begin
                vpipe_r <= {vpipe_r[MUL_LAT-2:0], op_vld_r};
            end
        end
    end

    // Control FSM with registered handshake, read and multiplier-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
            res_ovf_r   <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            mul_start_r <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ctl.cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        acc_r       <= {ACC_W{1'b0}};
                        ovf_r       <= 1'b0;
                        if (ctl.cmd_len == {LEN_W{1'b0}}) begin
                            state_r     <= DONE;
                            res_valid_r <= 1'b1;
                            res_data_r  <= {ACC_W{1'b0}};
                            res_ovf_r   <= 1'b0;
                        end else begin
                            state_r     <= FETCH;
                            rd_en_r     <= 1'b1;
                            rd_addr_r   <= ctl.cmd_base;
                            cnt_r       <= ctl.cmd_len - LEN_W'(1);
                            mul_start_r <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    acc_r <= acc_nxt_s;
                    ovf_r <= ovf_nxt_s;
                    if (cnt_r == {LEN_W{1'b0}}) begin
                        rd_en_r <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                        cnt_r     <= cnt_r - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    acc_r <= acc_nxt_s;
                    ovf_r <= ovf_nxt_s;
                    if (drained_s) begin
                        state_r     <= DONE;
                        mul_start_r <= 1'b0;
                        res_valid_r <= 1'b1;
                        res_data_r  <= acc_nxt_s;
                        res_ovf_r   <= ovf_nxt_s;
                    end
                end
                DONE: begin
                    if (ctl.res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                    rd_en_r     <= 1'b0;
                    mul_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign ctl.cmd_ready = cmd_ready_r;
    assign ctl.busy      = busy_r;
    assign ctl.res_valid = res_valid_r;
    assign ctl.res_data  = res_data_r;
`ifdef SVM_DOT_SAT_EN
    assign ctl.res_ovf   = res_ovf_r;
`else
    assign ctl.res_ovf   = 1'b0;
`endif
    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign mul_en    = mul_start_r;
    assign mul_start = mul_start_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;

endmodule
